// File: rtl/and_term_frame_rx_if.sv
// ============================================================================
// Module   : and_term_frame_rx_if
// Brief    : Serial term-link input and decoded-frame output bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface and_term_frame_rx_if;
    logic        s_valid;
    logic        s_sof;
    logic        s_data;
    logic        s_ready;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_in;
    logic [10:0] m_terms;
    logic [10:0] m_err_mask;
    logic        m_err;
    logic        m_abort;

    modport master (
        output s_valid, s_sof, s_data, m_ready,
        input  s_ready, m_valid, m_in, m_terms, m_err_mask, m_err, m_abort
    );

    modport slave (
        input  s_valid, s_sof, s_data, m_ready,
        output s_ready, m_valid, m_in, m_terms, m_err_mask, m_err, m_abort
    );
endinterface

`default_nettype wire

// File: rtl/and_term_frame_rx.sv
// ============================================================================
// Module   : and_term_frame_rx
// Brief    : Deserialises 15-bit AND-term frames and flags terms that disagree
//            with the recomputed products. Stats counters: AND_TERM_RX_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module and_term_frame_rx #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    and_term_frame_rx_if.slave   bus
`ifdef AND_TERM_RX_STATS_EN
    ,
    output logic [CNT_W-1:0]     stat_frames,
    output logic [CNT_W-1:0]     stat_errs
`endif
);

    if (TIMEOUT < 2 || TIMEOUT > 65535 || CNT_W < 1) begin : g_bad_param
        $error("and_term_frame_rx: parameter out of range");
    end

    localparam logic [15:0] c_TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  c_LAST_BIT = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [13:0] r_bits;
    logic [3:0]  r_cnt;
    logic [15:0] r_idle;
    logic        r_s_ready;
    logic        r_m_valid;
    logic [3:0]  r_m_in;
    logic [10:0] r_m_terms;
    logic [10:0] r_m_err_mask;
    logic        r_m_err;
    logic        r_m_abort;

    logic        w_xfer;
    logic        w_store;
    logic [3:0]  w_idx;
    logic [3:0]  w_cnt_next;
    logic [15:0] w_idle_next;
    logic        w_abort;
    logic        w_done;
    logic        w_release;
    logic [14:0] w_frame;
    logic [10:0] w_mask;

    function automatic logic [10:0] f_terms(input logic [3:0] v);
        logic i1, i2, i3, i4;
        {i4, i3, i2, i1} = v;
        return {i2 & i3 & i4, i1 & i3 & i4, i3 & i4, i2 & i4, i2 & i3,
                i1 & i4, i1 & i3, i1 & i2 & i4, i1 & i2 & i3 & i4,
                i1 & i2 & i3, i1 & i2};
    endfunction

    assign w_xfer  = bus.s_valid & r_s_ready;
    // Bit 14 is never stored; it is consumed straight from the link on completion.
    assign w_frame = {bus.s_data, r_bits};
    assign w_mask  = w_frame[14:4] ^ f_terms(w_frame[3:0]);

    always_comb begin
        w_next      = r_state;
        w_store     = 1'b0;
        w_idx       = r_cnt;
        w_cnt_next  = r_cnt;
        w_idle_next = r_idle;
        w_abort     = 1'b0;
        w_done      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_idle_next = '0;
                if (w_xfer && bus.s_sof) begin
                    w_store    = 1'b1;
                    w_idx      = 4'd0;
                    w_cnt_next = 4'd1;
                    w_next     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_xfer) begin
                    w_idle_next = '0;
                    if (bus.s_sof) begin
                        w_store    = 1'b1;
                        w_idx      = 4'd0;
                        w_cnt_next = 4'd1;
                        w_abort    = 1'b1;
                    end else if (r_cnt == c_LAST_BIT) begin
                        w_done     = 1'b1;
                        w_cnt_next = 4'd0;
                        w_next     = ST_OUT;
                    end else begin
                        w_store    = 1'b1;
                        w_cnt_next = r_cnt + 4'd1;
                    end
                end else if (r_idle == c_TO_LAST) begin
                    w_idle_next = '0;
                    w_cnt_next  = 4'd0;
                    w_abort     = 1'b1;
                    w_next      = ST_IDLE;
                end else begin
                    w_idle_next = r_idle + 16'd1;
                end
            end
            ST_OUT: begin
                if (r_m_valid && bus.m_ready) begin
                    w_release = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bits       <= '0;
            r_cnt        <= '0;
            r_idle       <= '0;
            r_s_ready    <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_in       <= '0;
            r_m_terms    <= '0;
            r_m_err_mask <= '0;
            r_m_err      <= 1'b0;
            r_m_abort    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_idle    <= w_idle_next;
            r_s_ready <= (w_next != ST_OUT);
            r_m_abort <= w_abort;
            if (w_store) begin
                r_bits[w_idx] <= bus.s_data;
            end
            if (w_done) begin
                r_m_valid    <= 1'b1;
                r_m_in       <= w_frame[3:0];
                r_m_terms    <= w_frame[14:4];
                r_m_err_mask <= w_mask;
                r_m_err      <= |w_mask;
            end else if (w_release) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign bus.s_ready    = r_s_ready;
    assign bus.m_valid    = r_m_valid;
    assign bus.m_in       = r_m_in;
    assign bus.m_terms    = r_m_terms;
    assign bus.m_err_mask = r_m_err_mask;
    assign bus.m_err      = r_m_err;
    assign bus.m_abort    = r_m_abort;

`ifdef AND_TERM_RX_STATS_EN
    logic [CNT_W-1:0] r_stat_frames;
    logic [CNT_W-1:0] r_stat_errs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_frames <= '0;
            r_stat_errs   <= '0;
        end else if (w_release) begin
            if (r_stat_frames != '1) begin
                r_stat_frames <= r_stat_frames + 1'b1;
            end
            if (r_m_err && (r_stat_errs != '1)) begin
                r_stat_errs <= r_stat_errs + 1'b1;
            end
        end
    end

    assign stat_frames = r_stat_frames;
    assign stat_errs   = r_stat_errs;
`endif

endmodule

`default_nettype wire

// File: tb/tb_and_term_frame_rx.sv
// ============================================================================
// Module   : tb_and_term_frame_rx
// Brief    : Directed self-checking bench for and_term_frame_rx.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_and_term_frame_rx;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   n_abort = 0;
    int   n_valid = 0;

    and_term_frame_rx_if u_if ();

`ifdef AND_TERM_RX_STATS_EN
    logic [15:0] stat_frames;
    logic [15:0] stat_errs;
`endif

    and_term_frame_rx #(
        .TIMEOUT (64),
        .CNT_W   (16)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
`ifdef AND_TERM_RX_STATS_EN
        ,
        .stat_frames (stat_frames),
        .stat_errs   (stat_errs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (u_if.m_abort === 1'b1) n_abort++;
        if (u_if.m_valid === 1'b1) n_valid++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] mk(input logic [3:0] in_v, input logic [10:0] t);
        return {t, in_v};
    endfunction

    task automatic send_bits(input logic [14:0] f, input int lo, input int hi, input bit sof);
        for (int i = lo; i <= hi; i++) begin
            u_if.s_valid = 1'b1;
            u_if.s_sof   = sof && (i == lo);
            u_if.s_data  = f[i];
            tick();
        end
        u_if.s_valid = 1'b0;
        u_if.s_sof   = 1'b0;
        u_if.s_data  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        u_if.s_valid = 1'b1;
        u_if.s_sof   = 1'b1;
        u_if.s_data  = 1'b1;
        u_if.m_ready = 1'b1;
        tick();
        tick();
        checks++; if (u_if.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", u_if.m_valid); end
        checks++; if (u_if.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", u_if.s_ready); end
        checks++; if ({u_if.m_in, u_if.m_terms, u_if.m_err_mask, u_if.m_err, u_if.m_abort} !== 28'd0) begin
            errors++; $display("FAIL reset_m_data got %h/%h/%h/%b/%b want 0", u_if.m_in, u_if.m_terms, u_if.m_err_mask, u_if.m_err, u_if.m_abort);
        end
        u_if.s_valid = 1'b0;
        u_if.s_sof   = 1'b0;
        u_if.s_data  = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++; if (u_if.s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready got %b want 1", u_if.s_ready); end
        tick();
        checks++; if (u_if.m_valid !== 1'b0) begin errors++; $display("FAIL post_reset_no_frame got %b want 0", u_if.m_valid); end
    endtask

    task automatic test_clean();
        logic [14:0] f;
        int nv0;
        f = mk(4'b0111, 11'h053);
        u_if.m_ready = 1'b1;
        nv0 = n_valid;
        send_bits(f, 0, 13, 1'b1);
        checks++; if (u_if.m_valid !== 1'b0) begin errors++; $display("FAIL clean_early_valid got %b want 0", u_if.m_valid); end
        send_bits(f, 14, 14, 1'b0);
        checks++; if (u_if.m_valid !== 1'b1) begin errors++; $display("FAIL clean_valid got %b want 1", u_if.m_valid); end
        checks++; if (u_if.m_in !== 4'b0111) begin errors++; $display("FAIL clean_m_in got %b want 0111", u_if.m_in); end
        checks++; if (u_if.m_terms !== 11'b00001010011) begin errors++; $display("FAIL clean_terms got %b want 00001010011", u_if.m_terms); end
        checks++; if ({u_if.m_err_mask, u_if.m_err} !== 12'd0) begin errors++; $display("FAIL clean_err got %b/%b want 0/0", u_if.m_err_mask, u_if.m_err); end
        checks++; if (u_if.s_ready !== 1'b0) begin errors++; $display("FAIL clean_out_s_ready got %b want 0", u_if.s_ready); end
        tick();
        checks++; if (u_if.m_valid !== 1'b0) begin errors++; $display("FAIL clean_valid_drop got %b want 0", u_if.m_valid); end
        checks++; if (u_if.s_ready !== 1'b1) begin errors++; $display("FAIL clean_idle_s_ready got %b want 1", u_if.s_ready); end
        checks++; if (n_valid - nv0 !== 1) begin errors++; $display("FAIL clean_valid_cycles got %0d want 1", n_valid - nv0); end
    endtask

    task automatic test_err_term();
        u_if.m_ready = 1'b1;
        send_bits(mk(4'b0111, 11'h057), 0, 14, 1'b1);
        checks++; if (u_if.m_valid !== 1'b1) begin errors++; $display("FAIL err_valid got %b want 1", u_if.m_valid); end
        checks++; if (u_if.m_terms !== 11'h057) begin errors++; $display("FAIL err_terms got %h want 057", u_if.m_terms); end
        checks++; if (u_if.m_err_mask !== 11'b00000000100) begin errors++; $display("FAIL err_mask got %b want 00000000100", u_if.m_err_mask); end
        checks++; if (u_if.m_err !== 1'b1) begin errors++; $display("FAIL err_flag got %b want 1", u_if.m_err); end
        tick();
    endtask

    task automatic test_backpressure();
        int bad;
        u_if.m_ready = 1'b0;
        send_bits(mk(4'b1011, 11'h0A9), 0, 14, 1'b1);
        checks++; if (u_if.m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", u_if.m_valid); end
        bad = 0;
        u_if.s_valid = 1'b1;
        u_if.s_sof   = 1'b1;
        u_if.s_data  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (u_if.m_valid !== 1'b1 || u_if.m_in !== 4'b1011 || u_if.m_terms !== 11'h0A9 ||
                u_if.m_err !== 1'b0 || u_if.s_ready !== 1'b0 || u_if.m_abort !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
        u_if.s_valid = 1'b0;
        u_if.s_sof   = 1'b0;
        u_if.s_data  = 1'b0;
        u_if.m_ready = 1'b1;
        tick();
        checks++; if (u_if.m_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", u_if.m_valid); end
        checks++; if (u_if.s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_s_ready got %b want 1", u_if.s_ready); end
    endtask

    task automatic test_restart();
        logic [14:0] b;
        int na0, nv0;
        b = mk(4'b1111, 11'h7FF);
        u_if.m_ready = 1'b1;
        na0 = n_abort;
        nv0 = n_valid;
        send_bits(mk(4'b0110, 11'h3C5), 0, 6, 1'b1);
        send_bits(b, 0, 0, 1'b1);
        checks++; if (u_if.m_abort !== 1'b1) begin errors++; $display("FAIL restart_abort got %b want 1", u_if.m_abort); end
        send_bits(b, 1, 14, 1'b0);
        checks++; if (u_if.m_valid !== 1'b1 || u_if.m_in !== 4'b1111 || u_if.m_terms !== 11'h7FF || u_if.m_err !== 1'b0) begin
            errors++; $display("FAIL restart_frame got v=%b in=%b t=%h e=%b want 1/1111/7ff/0", u_if.m_valid, u_if.m_in, u_if.m_terms, u_if.m_err);
        end
        tick();
        checks++; if (n_abort - na0 !== 1) begin errors++; $display("FAIL restart_abort_count got %0d want 1", n_abort - na0); end
        checks++; if (n_valid - nv0 !== 1) begin errors++; $display("FAIL restart_frames got %0d want 1", n_valid - nv0); end
    endtask

    task automatic test_timeout();
        int early, na0;
        u_if.m_ready = 1'b1;
        send_bits(mk(4'b0101, 11'h000), 0, 4, 1'b1);
        early = 0;
        for (int i = 1; i < 64; i++) begin
            tick();
            if (u_if.m_abort !== 1'b0) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL timeout_early got %0d pulses want 0", early); end
        tick();
        checks++; if (u_if.m_abort !== 1'b1) begin errors++; $display("FAIL timeout_abort got %b want 1", u_if.m_abort); end
        tick();
        checks++; if (u_if.m_abort !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width got %b want 0", u_if.m_abort); end
        na0 = n_abort;
        u_if.s_valid = 1'b1;
        u_if.s_sof   = 1'b0;
        u_if.s_data  = 1'b1;
        tick();
        u_if.s_valid = 1'b0;
        u_if.s_data  = 1'b0;
        tick();
        send_bits(mk(4'b1111, 11'h7FF), 0, 14, 1'b1);
        checks++; if (u_if.m_valid !== 1'b1 || u_if.m_in !== 4'b1111 || u_if.m_err !== 1'b0) begin
            errors++; $display("FAIL timeout_next_frame got v=%b in=%b e=%b want 1/1111/0", u_if.m_valid, u_if.m_in, u_if.m_err);
        end
        checks++; if (n_abort - na0 !== 0) begin errors++; $display("FAIL timeout_discard got %0d aborts want 0", n_abort - na0); end
        tick();
    endtask

    task automatic test_timeout_vs_xfer();
        logic [14:0] f;
        int na0;
        f = mk(4'b1100, 11'h100);
        u_if.m_ready = 1'b1;
        na0 = n_abort;
        send_bits(f, 0, 0, 1'b1);
        for (int i = 1; i < 64; i++) tick();
        send_bits(f, 1, 14, 1'b0);
        checks++; if (u_if.m_valid !== 1'b1 || u_if.m_in !== 4'b1100 || u_if.m_terms !== 11'h100 || u_if.m_err !== 1'b0) begin
            errors++; $display("FAIL xfer_wins_frame got v=%b in=%b t=%h e=%b want 1/1100/100/0", u_if.m_valid, u_if.m_in, u_if.m_terms, u_if.m_err);
        end
        checks++; if (n_abort - na0 !== 0) begin errors++; $display("FAIL xfer_wins_abort got %0d want 0", n_abort - na0); end
        tick();
    endtask

    task automatic test_sof_on_last();
        logic [14:0] b;
        b = mk(4'b0011, 11'h001);
        u_if.m_ready = 1'b1;
        send_bits(mk(4'b1111, 11'h7FF), 0, 13, 1'b1);
        send_bits(b, 0, 0, 1'b1);
        checks++; if (u_if.m_valid !== 1'b0 || u_if.m_abort !== 1'b1) begin
            errors++; $display("FAIL sof14_restart got v=%b abort=%b want 0/1", u_if.m_valid, u_if.m_abort);
        end
        send_bits(b, 1, 14, 1'b0);
        checks++; if (u_if.m_valid !== 1'b1 || u_if.m_in !== 4'b0011 || u_if.m_terms !== 11'h001 || u_if.m_err_mask !== 11'd0) begin
            errors++; $display("FAIL sof14_frame got v=%b in=%b t=%h m=%h want 1/0011/001/000", u_if.m_valid, u_if.m_in, u_if.m_terms, u_if.m_err_mask);
        end
        tick();
    endtask

`ifdef AND_TERM_RX_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (stat_frames !== 16'd0 || stat_errs !== 16'd0) begin
            errors++; $display("FAIL stats_zero got %0d/%0d want 0/0", stat_frames, stat_errs);
        end
        u_if.m_ready = 1'b1;
        send_bits(mk(4'b0111, 11'h053), 0, 14, 1'b1);
        tick();
        send_bits(mk(4'b0111, 11'h057), 0, 14, 1'b1);
        tick();
        send_bits(mk(4'b1011, 11'h0A9), 0, 14, 1'b1);
        tick();
        checks++; if (stat_frames !== 16'd3) begin errors++; $display("FAIL stats_frames got %0d want 3", stat_frames); end
        checks++; if (stat_errs !== 16'd1) begin errors++; $display("FAIL stats_errs got %0d want 1", stat_errs); end
    endtask
`endif

    task automatic test_reset_mid();
        u_if.m_ready = 1'b1;
        send_bits(mk(4'b1111, 11'h7FF), 0, 6, 1'b1);
        u_if.s_valid = 1'b1;
        u_if.s_data  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (u_if.s_ready !== 1'b0 || u_if.m_valid !== 1'b0 || u_if.m_in !== 4'd0 ||
                      u_if.m_terms !== 11'd0 || u_if.m_err !== 1'b0 || u_if.m_abort !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs got r=%b v=%b in=%b t=%h e=%b a=%b want all 0",
                               u_if.s_ready, u_if.m_valid, u_if.m_in, u_if.m_terms, u_if.m_err, u_if.m_abort);
        end
`ifdef AND_TERM_RX_STATS_EN
        checks++; if (stat_frames !== 16'd0 || stat_errs !== 16'd0) begin
            errors++; $display("FAIL mid_reset_stats got %0d/%0d want 0/0", stat_frames, stat_errs);
        end
`endif
        tick();
        u_if.s_valid = 1'b0;
        u_if.s_data  = 1'b0;
        rst_n = 1'b1;
        tick();
        send_bits(mk(4'b0011, 11'h001), 0, 14, 1'b1);
        checks++; if (u_if.m_valid !== 1'b1 || u_if.m_in !== 4'b0011 || u_if.m_terms !== 11'h001 || u_if.m_err !== 1'b0) begin
            errors++; $display("FAIL mid_reset_recover got v=%b in=%b t=%h e=%b want 1/0011/001/0", u_if.m_valid, u_if.m_in, u_if.m_terms, u_if.m_err);
        end
        tick();
    endtask

    initial begin
        u_if.s_valid = 1'b0;
        u_if.s_sof   = 1'b0;
        u_if.s_data  = 1'b0;
        u_if.m_ready = 1'b0;
        rst_n        = 1'b1;
        #1;
        test_reset();
        test_clean();
        test_err_term();
        test_backpressure();
        test_restart();
        test_timeout();
        test_timeout_vs_xfer();
        test_sof_on_last();
`ifdef AND_TERM_RX_STATS_EN
        test_stats();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
